secure_xfer_ctrl: RTL

- Parametrised, sequenced successor to the fixed memory/register/security datapath.
- Moves bursts of words between the data memory and the register file under key authorisation: load (mem->reg) and store (reg->mem).
- Optional key-derived data scrambling.
- Locks out after repeated key failures.
- Sits between the request source and the memory/register-file secondary ports; replaces the combinational security path.

---
 rtl/secure_xfer_ctrl_if.sv | 49 ++++
 rtl/secure_xfer_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/secure_xfer_ctrl_if.sv
// Request, key and memory/register-file secondary-port bundle for secure_xfer_ctrl.
// The controller takes the slave view; the request source and storage take the master view.
interface secure_xfer_ctrl_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter int KEY_W      = 16,
  parameter int LEN_W      = 4,
  parameter int LOCK_LIMIT = 3
);
  localparam int FC_W = $clog2(LOCK_LIMIT + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ADDR_W-1:0] req_mem_addr;
  logic [ADDR_W-1:0] req_reg_addr;
  logic [LEN_W-1:0]  req_len;
  logic [KEY_W-1:0]  req_key;
  logic [KEY_W-1:0]  mem_key;
  logic [KEY_W-1:0]  reg_key;
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              reg_ren;
  logic              reg_wen;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              done;
  logic              err;
  logic              locked;
  logic [FC_W-1:0]   fail_cnt;

  modport slave (
    input  req_valid, req_op, req_mem_addr, req_reg_addr, req_len, req_key,
           mem_key, reg_key, mem_rdata, reg_rdata,
    output req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
           reg_ren, reg_wen, reg_addr, reg_wdata, done, err, locked, fail_cnt
  );

  modport master (
    output req_valid, req_op, req_mem_addr, req_reg_addr, req_len, req_key,
           mem_key, reg_key, mem_rdata, reg_rdata,
    input  req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
           reg_ren, reg_wen, reg_addr, reg_wdata, done, err, locked, fail_cnt
  );
endinterface

// File: rtl/secure_xfer_ctrl.sv
// Key-authorised burst mover between data memory and register file (load/store),
// with optional key scrambling and lockout after repeated key failures.
module secure_xfer_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int KEY_W       = 16,
  parameter int LEN_W       = 4,
  parameter int LOCK_LIMIT  = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int SCRAMBLE    = 1
) (
  input  logic               clk,
  input  logic               rst,
  secure_xfer_ctrl_if.slave  bus
);
  localparam int FC_W = $clog2(LOCK_LIMIT + 1);
  localparam int LC_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CHECK, RD, WR, DONE, LOCK} state_t;

  state_t            state, state_nxt;
  logic              op_q;
  logic [ADDR_W-1:0] mem_base_q;
  logic [ADDR_W-1:0] reg_base_q;
  logic [LEN_W-1:0]  len_q;
  logic [KEY_W-1:0]  key_q;
  logic [LEN_W-1:0]  idx_q;
  logic [FC_W-1:0]   fail_cnt_q;
  logic              err_q;
  logic [LC_W-1:0]   lock_cnt_q;

  logic              key_ok;
  logic              len_zero;
  logic              last_word;
  logic              lock_hit;
  logic              lock_entry;
  logic [FC_W-1:0]   fail_inc;
  logic [ADDR_W-1:0] mem_ptr;
  logic [ADDR_W-1:0] reg_ptr;
  logic [DATA_W-1:0] mask;

  function automatic logic [DATA_W-1:0] scramble_mask(input logic [KEY_W-1:0] k);
    logic [DATA_W-1:0] m;
    m = '0;
    if (SCRAMBLE != 0) begin
      for (int i = 0; i < DATA_W / KEY_W; i++) m[i*KEY_W +: KEY_W] = k;
    end
    return m;
  endfunction

  assign key_ok     = (key_q == (op_q ? bus.reg_key : bus.mem_key));
  assign len_zero   = (len_q == '0);
  assign last_word  = (idx_q == len_q - LEN_W'(1));
  assign fail_inc   = fail_cnt_q + FC_W'(1);
  assign lock_hit   = (fail_inc == FC_W'(LOCK_LIMIT));
  assign lock_entry = (state == LOCK) && (lock_cnt_q == LC_W'(LOCK_CYCLES - 1));
  assign mem_ptr    = mem_base_q + ADDR_W'(idx_q);
  assign reg_ptr    = reg_base_q + ADDR_W'(idx_q);
  assign mask       = scramble_mask(key_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.req_valid) state_nxt = CHECK;
      CHECK: begin
        if (len_zero)     state_nxt = DONE;
        else if (key_ok)  state_nxt = RD;
        else if (lock_hit) state_nxt = LOCK;
        else              state_nxt = DONE;
      end
      RD:    state_nxt = WR;
      WR:    state_nxt = last_word ? DONE : RD;
      DONE:  state_nxt = IDLE;
      LOCK:  if (lock_cnt_q == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // request capture: key is held for the whole burst so key input changes mid-burst are ignored
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req_valid) begin
      op_q       <= bus.req_op;
      mem_base_q <= bus.req_mem_addr;
      reg_base_q <= bus.req_reg_addr;
      len_q      <= bus.req_len;
      key_q      <= bus.req_key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      fail_cnt_q <= '0;
      err_q      <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          idx_q <= '0;
          err_q <= 1'b0;
        end
        CHECK: begin
          if (len_zero) begin
            err_q <= 1'b1;
          end else if (!key_ok) begin
            fail_cnt_q <= fail_inc;
            err_q      <= 1'b1;
            if (lock_hit) lock_cnt_q <= LC_W'(LOCK_CYCLES - 1);
          end
        end
        WR:   if (!last_word) idx_q <= idx_q + LEN_W'(1);
        DONE: if (!err_q) fail_cnt_q <= '0;
        LOCK: begin
          if (lock_cnt_q == '0) fail_cnt_q <= '0;
          else                  lock_cnt_q <= lock_cnt_q - LC_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.locked    = (state == LOCK);
    bus.fail_cnt  = fail_cnt_q;
    bus.done      = (state == DONE) || lock_entry;
    bus.err       = ((state == DONE) && err_q) || lock_entry;
    bus.mem_ren   = 1'b0;
    bus.mem_wen   = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.reg_ren   = 1'b0;
    bus.reg_wen   = 1'b0;
    bus.reg_addr  = '0;
    bus.reg_wdata = '0;
    case (state)
      RD: begin
        if (op_q) begin
          bus.reg_ren  = 1'b1;
          bus.reg_addr = reg_ptr;
        end else begin
          bus.mem_ren  = 1'b1;
          bus.mem_addr = mem_ptr;
        end
      end
      WR: begin
        if (op_q) begin
          bus.mem_wen   = 1'b1;
          bus.mem_addr  = mem_ptr;
          bus.mem_wdata = bus.reg_rdata ^ mask;
        end else begin
          bus.reg_wen   = 1'b1;
          bus.reg_addr  = reg_ptr;
          bus.reg_wdata = bus.mem_rdata ^ mask;
        end
      end
      default: ;
    endcase
  end
endmodule
